// File: rtl/miriscv_data_mem.sv
// -----------------------------------------------------------------------------
// miriscv_data_mem
//
// Single-port data memory acting as the responder on the core's data-memory
// protocol. Each access takes two cycles: it is accepted in IDLE and its
// response is presented in RESP. A request held high across both cycles
// therefore executes exactly once, and back-to-back requests run at one
// transaction per two cycles.
//
// Parameters
//   MEM_WORDS  number of 32-bit words (power of two, >= 4)
//   BASE_ADDR  byte address of word 0 (aligned to MEM_WORDS*4)
//
// Ports
//   clk_i          clock, rising edge
//   arstn_i        asynchronous reset, active-high
//   data_req_i     access request, held for the whole transaction
//   data_we_i      1 = write, 0 = read
//   data_be_i      byte-lane enables for writes
//   data_addr_i    byte address, bits [1:0] ignored for indexing
//   data_wdata_i   lane-replicated write data
//   data_rdata_o   registered read word, held until the next read
//   data_rvalid_o  read result valid (RESP cycle only)
//   data_err_o     access was out of range (RESP cycle only)
// -----------------------------------------------------------------------------
module miriscv_data_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rvalid_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  // One bit wider than the address so a 4 GiB memory does not wrap to zero.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e            state_q;
  logic [31:0]       mem [MEM_WORDS];

  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;

  // Address decode. The lower-bound test catches addresses below BASE_ADDR,
  // whose offset would otherwise wrap around to a large value.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign idx      = offset[IDX_W+1:2];

  // A write commits only on the accept edge. Reset is folded in so that a
  // request sitting on the bus while reset is asserted never reaches the array.
  assign wr_en = (state_q == IDLE) && data_req_i && data_we_i && in_range && !arstn_i;

  // NOTE: the array sits in its own clock-only block with no reset branch, so
  // it maps onto a plain RAM macro; its contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so the read of
  // mem[idx] below sees the pre-edge contents, independent of block ordering.
  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      state_q       <= IDLE;
      data_rdata_o  <= 32'h0;
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req_i) begin
            state_q       <= RESP;
            data_rvalid_o <= !data_we_i;
            data_err_o    <= !in_range;
            // Writes leave the last read word visible on data_rdata_o.
            if (!data_we_i) begin
              data_rdata_o <= in_range ? mem[idx] : 32'h0;
            end
          end
        end
        RESP: begin
          // Inputs are ignored here, so a held request is not re-executed.
          state_q       <= IDLE;
          data_rvalid_o <= 1'b0;
          data_err_o    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_data_mem.sv
// -----------------------------------------------------------------------------
// tb_miriscv_data_mem
//
// Directed bench for miriscv_data_mem (MEM_WORDS=1024, BASE_ADDR=0). The
// stimulus process pushes the hand-computed response of every transaction
// that produces one (reads and out-of-range accesses) into a queue; the
// monitor pops and compares whenever the DUT raises rvalid or err.
// -----------------------------------------------------------------------------
module tb_miriscv_data_mem;

  typedef struct {
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
  } rsp_t;

  logic        clk_i;
  logic        arstn_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_rvalid_o;
  logic        data_err_o;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  miriscv_data_mem #(
    .MEM_WORDS (1024),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .data_rvalid_o (data_rvalid_o),
    .data_err_o    (data_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic rvalid, input logic err);
    rsp_t r;
    r.rdata  = rdata;
    r.rvalid = rvalid;
    r.err    = err;
    exp_q.push_back(r);
  endtask

  // One two-cycle transaction with req held high. During RESP the address and
  // write data are switched to resp_addr/resp_wdata, which must be ignored.
  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] resp_addr,
                      input logic [31:0] resp_wdata);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    @(posedge clk_i); #1;
    data_addr_i  = resp_addr;
    data_wdata_i = resp_wdata;
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    xact(1'b1, be, addr, wdata, 32'hFFFF_FFF0, ~wdata);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data);
    expect_rsp(exp_data, 1'b1, 1'b0);
    xact(1'b0, 4'b0000, addr, 32'h0, 32'hFFFF_FFF0, 32'h0);
  endtask

  task automatic idle();
    data_req_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // Monitor: every response the DUT presents must match the queue head.
  always @(negedge clk_i) begin
    if (!arstn_i && (data_rvalid_o || data_err_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rvalid=%b err=%b rdata=%h expected no response",
                 data_rvalid_o, data_err_o, data_rdata_o);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rvalid", {31'h0, data_rvalid_o}, {31'h0, e.rvalid});
        check("rsp_err", {31'h0, data_err_o}, {31'h0, e.err});
        if (e.rvalid) check("rsp_rdata", data_rdata_o, e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn_i      = 1'b1;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'b0000;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_rdata", data_rdata_o, 32'h0);
    check("reset_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    check("reset_err", {31'h0, data_err_o}, 32'h0);
    arstn_i = 1'b0;

    // Write and read back; rvalid drops in the cycle after RESP.
    wr(32'h10, 4'b1111, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF);
    check("rvalid_after_resp", {31'h0, data_rvalid_o}, 32'h0);
    check("err_after_resp", {31'h0, data_err_o}, 32'h0);
    idle();

    // Byte lanes; addr[1:0] ignored.
    wr(32'h20, 4'b1111, 32'h1122_3344);
    wr(32'h20, 4'b0100, 32'hAAAA_AAAA);
    rd(32'h20, 32'h11AA_3344);
    rd(32'h22, 32'h11AA_3344);
    idle();

    // Zero byte enables: no change, no error.
    wr(32'h50, 4'b1111, 32'h5555_5555);
    wr(32'h50, 4'b0000, 32'hFFFF_FFFF);
    rd(32'h50, 32'h5555_5555);
    idle();

    // Single execution: RESP-cycle changes are ignored; a 4-cycle held request
    // writes twice, each with its own accept-cycle values.
    wr(32'h30, 4'b1111, 32'h0000_0000);
    wr(32'h40, 4'b1111, 32'h0000_0000);
    wr(32'h44, 4'b1111, 32'hFFFF_FFFF);
    wr(32'h48, 4'b1111, 32'h0000_0000);
    idle();
    xact(1'b1, 4'b1111, 32'h30, 32'h0000_0001, 32'h30, 32'h0000_0002);
    idle();
    rd(32'h30, 32'h0000_0001);
    idle();
    xact(1'b1, 4'b1111, 32'h40, 32'h0101_0101, 32'h44, 32'h0202_0202);
    xact(1'b1, 4'b1111, 32'h44, 32'h0202_0202, 32'h48, 32'h0303_0303);
    idle();
    rd(32'h40, 32'h0101_0101);
    rd(32'h44, 32'h0202_0202);
    rd(32'h48, 32'h0000_0000);
    idle();

    // Out of range: 0x1000 would alias word 0 if the range check were missing.
    wr(32'h0, 4'b1111, 32'hCAFE_F00D);
    rd(32'h0, 32'hCAFE_F00D);
    expect_rsp(32'h0, 1'b0, 1'b1);
    wr(32'h1000, 4'b1111, 32'h1234_5678);
    check("rdata_held_over_write", data_rdata_o, 32'hCAFE_F00D);
    expect_rsp(32'h0, 1'b1, 1'b1);
    xact(1'b0, 4'b1111, 32'h1000, 32'h0, 32'h0, 32'h0);
    rd(32'h0, 32'hCAFE_F00D);
    idle();

    // Back-to-back alternating write/read, req held throughout.
    wr(32'h60, 4'b1111, 32'hA0A0_A0A0);
    rd(32'h60, 32'hA0A0_A0A0);
    wr(32'h64, 4'b1111, 32'hB1B1_B1B1);
    rd(32'h64, 32'hB1B1_B1B1);
    wr(32'h60, 4'b1000, 32'hC2C2_C2C2);
    rd(32'h60, 32'hC2A0_A0A0);
    wr(32'h68, 4'b1111, 32'h0D0D_0D0D);
    rd(32'h68, 32'h0D0D_0D0D);

    // Reset in the RESP cycle of a read, after the monitor has sampled it.
    expect_rsp(32'h0D0D_0D0D, 1'b1, 1'b0);
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = 32'h68;
    @(posedge clk_i); #1;
    @(negedge clk_i); #2;
    arstn_i = 1'b1;
    #1;
    check("rst_resp_rdata", data_rdata_o, 32'h0);
    check("rst_resp_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    check("rst_resp_err", {31'h0, data_err_o}, 32'h0);
    // A write presented while reset is held must not commit.
    data_we_i    = 1'b1;
    data_be_i    = 4'b1111;
    data_addr_i  = 32'h64;
    data_wdata_i = 32'hEEEE_EEEE;
    @(posedge clk_i); #1;
    check("rst_hold_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    arstn_i = 1'b0;
    // The next request is accepted on the first edge after release.
    expect_rsp(32'hB1B1_B1B1, 1'b1, 1'b0);
    data_we_i   = 1'b0;
    data_addr_i = 32'h64;
    @(posedge clk_i); #1;
    check("post_rst_accept", {31'h0, data_rvalid_o}, 32'h1);
    @(posedge clk_i); #1;
    idle();
    idle();

    check("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
